// File: rtl/pwm_core_mc.sv
// Multi-channel PWM core: shared period counter, per-channel compare; PWM_CORE_MC_SHADOW_EN adds period-boundary shadow regs.
// Latency: o_pwm/period_end registered, one cycle behind the count; no backpressure, free-running.
module pwm_core_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pwm_core_EN,
    input  logic                      main_counter_EN,
    input  logic                      center_mode,
    input  logic [WIDTH-1:0]          period_reg,
    input  logic [CHANNELS*WIDTH-1:0] duty_reg,
    input  logic [CHANNELS*WIDTH-1:0] i_DC,
    input  logic [CHANNELS-1:0]       duty_sel,
    input  logic [CHANNELS-1:0]       o_pwm_EN,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      period_end
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    logic [WIDTH-1:0]          cnt_q;
    dir_e                      dir_q;
    logic [CHANNELS-1:0]       o_pwm_q;
    logic [CHANNELS-1:0]       o_pwm_d;
    logic                      period_end_q;

    logic [CHANNELS*WIDTH-1:0] duty_mux;
    logic [WIDTH-1:0]          per_w;
    logic                      mode_w;
    logic [CHANNELS*WIDTH-1:0] duty_w;
    logic                      mode_chg;

    logic                      per_zero;
    logic [WIDTH-1:0]          per_m1;
    logic                      over;
    logic                      term_pt;
    logic                      terminal;

    always_comb begin
        duty_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_mux[i*WIDTH +: WIDTH] = duty_sel[i] ? i_DC[i*WIDTH +: WIDTH]
                                                     : duty_reg[i*WIDTH +: WIDTH];
        end
    end

`ifdef PWM_CORE_MC_SHADOW_EN
    logic [WIDTH-1:0]          per_sh_q;
    logic                      mode_sh_q;
    logic [CHANNELS*WIDTH-1:0] duty_sh_q;
    logic                      load;

    // Shadows reload while idle, while the period is zero, or at the terminal edge.
    assign load = !pwm_core_EN || (main_counter_EN && (per_zero || terminal));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_sh_q  <= '0;
            mode_sh_q <= 1'b0;
            duty_sh_q <= '0;
        end else if (load) begin
            per_sh_q  <= period_reg;
            mode_sh_q <= center_mode;
            duty_sh_q <= duty_mux;
        end
    end

    assign per_w    = per_sh_q;
    assign mode_w   = mode_sh_q;
    assign duty_w   = duty_sh_q;
    assign mode_chg = 1'b0;
`else
    logic mode_q;

    // Without shadows a live mode switch must restart the count from the bottom, heading up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (!pwm_core_EN || main_counter_EN) begin
            mode_q <= center_mode;
        end
    end

    assign per_w    = period_reg;
    assign mode_w   = center_mode;
    assign duty_w   = duty_mux;
    assign mode_chg = (mode_q != center_mode);
`endif

    always_comb begin
        per_zero = (per_w == '0);
        per_m1   = per_w - WIDTH'(1);
        over     = (cnt_q > per_m1);
        if (!mode_w) begin
            term_pt = (cnt_q >= per_m1);
        end else begin
            term_pt = over || ((dir_q == DIR_DOWN) && (cnt_q == '0));
        end
        terminal = pwm_core_EN && main_counter_EN && !per_zero && !mode_chg && term_pt;
    end

    always_comb begin
        o_pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_pwm_d[i] = pwm_core_EN && o_pwm_EN[i] && !per_zero &&
                         (cnt_q < duty_w[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            o_pwm_q      <= '0;
            period_end_q <= 1'b0;
        end else begin
            o_pwm_q      <= o_pwm_d;
            period_end_q <= terminal;
            if (!pwm_core_EN) begin
                cnt_q <= '0;
                dir_q <= DIR_UP;
            end else if (main_counter_EN) begin
                if (mode_chg || per_zero || terminal) begin
                    cnt_q <= '0;
                    dir_q <= DIR_UP;
                end else if (!mode_w) begin
                    cnt_q <= cnt_q + WIDTH'(1);
                end else if (dir_q == DIR_UP) begin
                    // The top value is held for a second cycle while the direction turns.
                    if (cnt_q == per_m1) begin
                        dir_q <= DIR_DOWN;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end else begin
                    cnt_q <= cnt_q - WIDTH'(1);
                end
            end
        end
    end

    assign o_pwm      = o_pwm_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_core_mc.sv
// Scoreboarded bench for pwm_core_mc: period-position reference model plus directed duty/period measurements.
module tb_pwm_core_mc;
    localparam int W  = 16;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pwm_core_EN;
    logic            main_counter_EN;
    logic            center_mode;
    logic [W-1:0]    period_reg;
    logic [CH*W-1:0] duty_reg;
    logic [CH*W-1:0] i_DC;
    logic [CH-1:0]   duty_sel;
    logic [CH-1:0]   o_pwm_EN;
    logic [CH-1:0]   o_pwm;
    logic            period_end;

    always #5 clk = ~clk;

    pwm_core_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pwm_core_EN    (pwm_core_EN),
        .main_counter_EN(main_counter_EN),
        .center_mode    (center_mode),
        .period_reg     (period_reg),
        .duty_reg       (duty_reg),
        .i_DC           (i_DC),
        .duty_sel       (duty_sel),
        .o_pwm_EN       (o_pwm_EN),
        .o_pwm          (o_pwm),
        .period_end     (period_end)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          pe;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   mon_on = 1'b0;

    // Reference model: position t within the current period, count derived arithmetically.
    int m_t;
    int m_psh;
    bit m_msh;
    int m_dsh[CH];
    bit m_pmode;

    function automatic int sel_duty(input int i);
        return duty_sel[i] ? int'(i_DC[i*W +: W]) : int'(duty_reg[i*W +: W]);
    endfunction

    task automatic model_reset();
        m_t = 0; m_psh = 0; m_msh = 1'b0; m_pmode = 1'b0;
        for (int i = 0; i < CH; i++) m_dsh[i] = 0;
    endtask

    task automatic model_step();
        int   p, len, c;
        int   d[CH];
        bit   m, chg, term;
        exp_t e;
`ifdef PWM_CORE_MC_SHADOW_EN
        p = m_psh; m = m_msh; chg = 1'b0;
        for (int i = 0; i < CH; i++) d[i] = m_dsh[i];
`else
        p = int'(period_reg); m = center_mode; chg = (m_pmode != center_mode);
        for (int i = 0; i < CH; i++) d[i] = sel_duty(i);
`endif
        len = m ? 2 * p : p;
        c   = (m && m_t >= p) ? (2 * p - 1 - m_t) : m_t;
        for (int i = 0; i < CH; i++)
            e.pwm[i] = pwm_core_EN && o_pwm_EN[i] && (p != 0) && (c < d[i]);
        term = pwm_core_EN && main_counter_EN && (p != 0) && !chg && (m_t >= len - 1);
        e.pe = term;
`ifdef PWM_CORE_MC_SHADOW_EN
        if (!pwm_core_EN || (main_counter_EN && (p == 0 || term))) begin
            m_psh = int'(period_reg);
            m_msh = center_mode;
            for (int i = 0; i < CH; i++) m_dsh[i] = sel_duty(i);
        end
`else
        if (!pwm_core_EN || main_counter_EN) m_pmode = center_mode;
`endif
        if (!pwm_core_EN) m_t = 0;
        else if (main_counter_EN) begin
            if (chg || p == 0 || term) m_t = 0;
            else m_t = m_t + 1;
        end
        sb_q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            sb_q.delete();
            sb_q.push_back('0);
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            if (mon_on) begin
                total++;
                if ({o_pwm, period_end} !== mon_e) begin
                    bad++;
                    $display("FAIL sb_cycle at %0t: got pwm=%b pe=%b, want pwm=%b pe=%b",
                             $time, o_pwm, period_end, mon_e.pwm, mon_e.pe);
                end
            end
        end else if (mon_on) begin
            total++;
            bad++;
            $display("FAIL sb_empty at %0t: no expected entry (got pwm=%b pe=%b)",
                     $time, o_pwm, period_end);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pe(output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < 1000 && !ok) begin
            @(negedge clk);
            n++;
            if (period_end) ok = 1'b1;
        end
        if (!ok) chk("pe_timeout", 0, 1);
    endtask

    task automatic measure(input int ch, input int ep, input int eh, input string name);
        int n, h;
        bit ok;
        wait_pe(n, ok);
        if (ok) begin
            h = int'(o_pwm[ch]);
            n = 1;
            ok = 1'b0;
            while (n < 1000 && !ok) begin
                @(negedge clk);
                if (period_end) ok = 1'b1;
                else begin
                    n++;
                    h += int'(o_pwm[ch]);
                end
            end
            chk({name, "_period"}, n, ep);
            chk({name, "_high"}, h, eh);
        end
    endtask

    task automatic set_duty(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < CH; i++) duty_reg[i*W +: W] = W'(v[i]);
    endtask

    task automatic set_idc(input int v);
        for (int i = 0; i < CH; i++) i_DC[i*W +: W] = W'(v);
    endtask

    task automatic reconfig(input int p, input bit m);
        pwm_core_EN = 1'b0;
        period_reg  = W'(p);
        center_mode = m;
        cyc(2);
        pwm_core_EN = 1'b1;
    endtask

    initial begin
        int n, h, r, pe_seen, chg_seen;
        bit ok;
        logic [CH-1:0] snap;

        rst = 1'b1;
        pwm_core_EN = 1'b1; main_counter_EN = 1'b1; center_mode = 1'b0;
        period_reg = W'(100); duty_sel = '0; o_pwm_EN = '1;
        set_duty(0, 25, 75, 100); set_idc(0);
        cyc(2);
        mon_on = 1'b1;
        cyc(2);
        chk("reset_pwm", int'(o_pwm), 0);
        chk("reset_pe", int'(period_end), 0);
        rst = 1'b0;

        // Edge mode, P=100, duties 0/25/75/100
        measure(0, 100, 0,   "edge_d0");
        measure(1, 100, 25,  "edge_d25");
        measure(2, 100, 75,  "edge_d75");
        measure(3, 100, 100, "edge_d100");

        // Center mode, P=100, D=30
        set_duty(30, 30, 30, 30);
        reconfig(100, 1'b1);
        measure(0, 200, 60, "center_d30");
        measure(0, 200, 60, "center_d30b");

        // Mid-period duty update at cnt=40
        set_duty(25, 25, 25, 25);
        reconfig(100, 1'b0);
        wait_pe(n, ok);
        h = int'(o_pwm[0]);
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (k == 40) set_duty(75, 75, 75, 75);
            h += int'(o_pwm[0]);
        end
`ifdef PWM_CORE_MC_SHADOW_EN
        chk("midupd_cur_high", h, 25);
`else
        chk("midupd_cur_high", h, 60);
`endif
        measure(0, 100, 75, "midupd_next");

        // Per-channel duty source select
        set_duty(15, 15, 15, 15); set_idc(60); duty_sel = 4'b0101;
        wait_pe(n, ok);
        measure(0, 100, 60, "sel_ch0");
        measure(1, 100, 15, "sel_ch1");
        measure(2, 100, 60, "sel_ch2");
        measure(3, 100, 15, "sel_ch3");

        // Counter hold
        duty_sel = '0; set_duty(10, 50, 90, 100);
        wait_pe(n, ok);
        wait_pe(n, ok);
        cyc(30);
        main_counter_EN = 1'b0;
        cyc(2);
        snap = o_pwm;
        chk("hold_level", int'(snap), 4'b1110);
        pe_seen = 0; chg_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            pe_seen += int'(period_end);
            if (o_pwm != snap) chg_seen++;
        end
        chk("hold_pe", pe_seen, 0);
        chk("hold_changes", chg_seen, 0);
        main_counter_EN = 1'b1;

        // Per-channel gate and global enable
        o_pwm_EN = 4'b1101;
        cyc(2);
        chk("gate_ch1_low", int'(o_pwm[1]), 0);
        chk("gate_ch3_high", int'(o_pwm[3]), 1);
        o_pwm_EN = '1;
        pwm_core_EN = 1'b0;
        cyc(2);
        chk("disable_pwm", int'(o_pwm), 0);
        chk("disable_pe", int'(period_end), 0);
        cyc(10);
        pwm_core_EN = 1'b1;
        wait_pe(n, ok);
        chk("restart_first_pe", n, 100);

        // Zero and unit periods
        reconfig(0, 1'b0);
        cyc(5);
        pe_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            pe_seen += int'(period_end);
        end
        chk("p0_pwm", int'(o_pwm), 0);
        chk("p0_pe", pe_seen, 0);
        set_duty(1, 1, 1, 1);
        reconfig(1, 1'b0);
        cyc(3);
        chk("p1_d1_pwm", int'(o_pwm), 4'hF);

        // Randomised phase, scoreboard only
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            pwm_core_EN = (r >= 3);
`ifdef PWM_CORE_MC_SHADOW_EN
            if (r < 12) begin
`else
            if (r < 3) begin
`endif
                period_reg  = W'($urandom_range(0, 12));
                center_mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < CH; i++) begin
                    duty_reg[i*W +: W] = W'($urandom_range(0, 14));
                    i_DC[i*W +: W]     = W'($urandom_range(0, 14));
                end
                duty_sel = CH'($urandom_range(0, 15));
            end
            main_counter_EN = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) o_pwm_EN = CH'($urandom_range(0, 15));
        end
        main_counter_EN = 1'b1; o_pwm_EN = '1; duty_sel = '0;

        // Asynchronous reset mid-period at cnt=57
        set_duty(0, 25, 75, 100);
        reconfig(100, 1'b0);
        wait_pe(n, ok);
        wait_pe(n, ok);
        cyc(57);
        chk("pre_rst_ch3", int'(o_pwm[3]), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm", int'(o_pwm), 0);
        chk("async_rst_pe", int'(period_end), 0);
        cyc(3);
        rst = 1'b0;
        cyc(250);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
